piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in, serial-out converter. It is the transmit-side counterpart of the team's serial-in, parallel-out shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out one bit per enabled clock, MSB-first or LSB-first.
- Flags the last bit of each frame.
- Feeds serial links and bit-level test paths driven from word-oriented logic.

Parameters:
WIDTH, 8, parallel word width in bits; legal range WIDTH >= 2.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rstn_i  input  1  reset, asynchronous, active-low
en_i  input  1  shift enable; a presented bit is consumed only on an edge where en_i=1
valid_i  input  1  parallel word on data_i is valid
ready_o  output  1  serializer can accept a word this cycle
data_i  input  WIDTH  parallel word, captured on accept
dir_i  input  1  bit order, captured on accept: 0 = MSB first, 1 = LSB first
data_o  output  1  current serial bit
sdv_o  output  1  data_o holds a valid frame bit
last_o  output  1  data_o holds the final bit of the frame

Behaviour:
- Reset: clock clk_i; reset rstn_i, asynchronous, active-low. While reset is asserted:
  - state = IDLE, shift register = 0, bit counter = 0, captured direction = 0.
  - data_o=0, sdv_o=0, last_o=0, ready_o=1.
- Reset mid-frame: aborts the frame immediately. No partial bits or last_o follow after release.
- States:
  - IDLE: ready_o=1, sdv_o=0, data_o=0.
  - SHIFT: sdv_o=1, data_o = current bit.
- Accept: occurs on a rising edge with valid_i=1 and ready_o=1.
  - Captures data_i and dir_i, clears the counter, enters SHIFT.
  - The first frame bit appears on data_o in the cycle after the accept edge.
- Bit selection:
  - Shift register held in flops; data_o is a register output (no combinational path from data_i).
  - dir=0: data_o = reg[WIDTH-1], shift left on consume.
  - dir=1: data_o = reg[0], shift right on consume.
  - Vacated positions fill with 0.
- Consume: on each edge in SHIFT with en_i=1, advance one bit and increment the counter (width $clog2(FRAME+1)).
  - FRAME = WIDTH, or WIDTH+1 with the optional feature compiled in.
- Stall: en_i=0 in SHIFT holds data_o, sdv_o, last_o and the counter unchanged, for any number of cycles.
- last_o: registered; high exactly while the final frame bit is presented.
- Frame end: on consuming the last bit:
  - with no new accept, return to IDLE.
  - with a simultaneous accept, stay in SHIFT with the new word.
- ready_o in SHIFT: ready_o = last_o & en_i (combinational), allowing back-to-back frames with zero idle cycles.
- ready_o is 0 in SHIFT otherwise. valid_i, data_i and dir_i are ignored while ready_o=0, and data_i changes mid-frame have no effect.
- Latency: accept edge to first bit = 1 cycle. With en_i held at 1, a frame occupies exactly FRAME cycles.
- No error outputs; no condition makes the block hang.

Optional Feature:
Macro PISO_PARITY_EN.
- Defined: FRAME = WIDTH+1. After the data bits, one extra bit is presented: even parity, the XOR of all WIDTH captured bits, computed at accept. last_o is asserted on the parity bit only; parity follows the data bits regardless of dir.
- Undefined: FRAME = WIDTH, no parity logic; last_o is asserted on data bit WIDTH-1.

Test Plan:
1. Reset, en_i=1, accept 8'hB4 with dir_i=0 -> data_o = 1,0,1,1,0,1,0,0 on cycles 1..8 after accept; sdv_o=1 on those cycles; last_o only on cycle 8; ready_o=1 and sdv_o=0 on cycle 9.
2. Accept 8'hB4 with dir_i=1, en_i=1 -> data_o = 0,0,1,0,1,1,0,1; last_o on the 8th bit.
3. Accept 8'hFF (dir 0), drop en_i for 3 cycles after the 2nd bit is consumed -> data_o/sdv_o hold during the stall; frame spans 11 cycles; last_o once.
4. valid_i held high with 8'h0F then 8'hF0 (dir 0), en_i=1 -> 16 consecutive bits 0000111111110000 with sdv_o never low; ready_o high only during cycle 8; a third word offered mid-frame is not accepted.
5. Accept 8'hAA, assert rstn_i low after 4 bits -> data_o, sdv_o, last_o are 0 immediately and ready_o=1; a new 8'h80 accept after release restarts at bit 0: 1,0,0,0,0,0,0,0.
6. With PISO_PARITY_EN: 8'h07 -> 8 data bits then a 9th bit = 1 with last_o; 8'h03 -> 9th bit = 0. Without the macro: last_o on the 8th bit and ready_o on the 9th cycle.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Handshake and serial-side signal bundle for piso_serializer.
// master: word producer / serial consumer; slave: the serializer itself.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_i;
    logic             dir_i;
    logic             data_o;
    logic             sdv_o;
    logic             last_o;

    modport master (
        output en_i,
        output valid_i,
        input  ready_o,
        output data_i,
        output dir_i,
        input  data_o,
        input  sdv_o,
        input  last_o
    );

    modport slave (
        input  en_i,
        input  valid_i,
        output ready_o,
        input  data_i,
        input  dir_i,
        output data_o,
        output sdv_o,
        output last_o
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out converter with valid/ready word intake.
// Words shift out MSB-first (dir=0) or LSB-first (dir=1), one bit per
// enabled clock; last_o marks the final bit of each frame.
// Optional macro PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk_i,
    input logic              rstn_i,
    piso_serializer_if.slave bus
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam int unsigned CW = $clog2(FRAME + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic             dir;
    logic             sbit;
    logic             sdv;
    logic             last;
    logic             ready;
    logic             accept;
    logic             consume;
`ifdef PISO_PARITY_EN
    logic             parity;
`endif

    // Handshake decode; ready reopens on the last bit so frames can abut.
    always_comb begin
        ready   = (state == IDLE) | (last & bus.en_i);
        accept  = bus.valid_i & ready;
        consume = (state == SHIFT) & bus.en_i;
        shifted = dir ? (shreg >> 1) : (shreg << 1);
    end

    // Drive the interface outputs from registered state.
    always_comb begin
        bus.ready_o = ready;
        bus.data_o  = sbit;
        bus.sdv_o   = sdv;
        bus.last_o  = last;
    end

    // Frame sequencer: accept, shift, and registered serial outputs.
    // An accept can only coincide with consuming the last bit, so it takes
    // priority and reloads directly for back-to-back frames.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            dir    <= 1'b0;
            sbit   <= 1'b0;
            sdv    <= 1'b0;
            last   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity <= 1'b0;
`endif
        end else if (accept) begin
            state  <= SHIFT;
            shreg  <= bus.data_i;
            dir    <= bus.dir_i;
            cnt    <= '0;
            sbit   <= bus.dir_i ? bus.data_i[0] : bus.data_i[WIDTH-1];
            sdv    <= 1'b1;
            last   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity <= ^bus.data_i;
`endif
        end else if (consume) begin
            if (last) begin
                state <= IDLE;
                shreg <= '0;
                cnt   <= '0;
                sbit  <= 1'b0;
                sdv   <= 1'b0;
                last  <= 1'b0;
            end else begin
                shreg <= shifted;
                cnt   <= cnt + 1'b1;
                last  <= (cnt == CW'(FRAME - 2));
`ifdef PISO_PARITY_EN
                if (cnt == CW'(WIDTH - 1)) begin
                    sbit <= parity;
                end else begin
                    sbit <= dir ? shifted[0] : shifted[WIDTH-1];
                end
`else
                sbit  <= dir ? shifted[0] : shifted[WIDTH-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed frames plus random
// traffic, compared against a bit-queue reference model.
module tb_piso_serializer;

    localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME = W + 1;
    localparam logic [31:0] E1  = 32'h168;
    localparam logic [31:0] E2  = 32'h05A;
    localparam logic [31:0] E4  = 32'h3DE0;
    localparam logic [31:0] E5  = 32'h101;
    localparam logic [31:0] E6A = 32'h00F;
    localparam logic [31:0] E6B = 32'h006;
`else
    localparam int unsigned FRAME = W;
    localparam logic [31:0] E1  = 32'hB4;
    localparam logic [31:0] E2  = 32'h2D;
    localparam logic [31:0] E4  = 32'h0FF0;
    localparam logic [31:0] E5  = 32'h80;
    localparam logic [31:0] E6A = 32'h07;
    localparam logic [31:0] E6B = 32'h03;
`endif

    logic clk = 1'b0;
    logic rstn;

    piso_serializer_if #(.WIDTH(W)) bus ();

    piso_serializer #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model: bits still to be presented, front = current bit.
    bit q[$];

    logic [31:0] cap;
    int unsigned capn, lastn, lastpos, readyn, sdvlow;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cap = '0; capn = 0; lastn = 0; lastpos = 0; readyn = 0; sdvlow = 0;
    endtask

    task automatic load(input logic [W-1:0] d, input logic dr);
        q.delete();
        for (int i = 0; i < int'(W); i++) q.push_back(dr ? d[i] : d[W-1-i]);
`ifdef PISO_PARITY_EN
        q.push_back(^d);
`endif
    endtask

    // One clock: drive inputs, check ready, advance model at the edge, check outputs.
    task automatic cycle(input logic en, input logic v, input logic [W-1:0] d, input logic dr);
        logic exp_ready, acc, exp_bit;
        bus.en_i = en; bus.valid_i = v; bus.data_i = d; bus.dir_i = dr;
        #1;
        exp_ready = (q.size() == 0) || (q.size() == 1 && en);
        chk("ready", {31'b0, bus.ready_o}, {31'b0, exp_ready});
        if (bus.ready_o) readyn++;
        acc = v && exp_ready;
        @(posedge clk);
        if (q.size() > 0 && en) void'(q.pop_front());
        if (acc) load(d, dr);
        #1;
        exp_bit = (q.size() > 0) ? q[0] : 1'b0;
        chk("sdv",  {31'b0, bus.sdv_o},  {31'b0, q.size() > 0});
        chk("data", {31'b0, bus.data_o}, {31'b0, exp_bit});
        chk("last", {31'b0, bus.last_o}, {31'b0, q.size() == 1});
        if (bus.sdv_o) begin
            cap = {cap[30:0], bus.data_o};
            capn++;
        end else begin
            sdvlow++;
        end
        if (bus.last_o) begin
            lastn++;
            lastpos = capn;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"},  {31'b0, bus.data_o},  32'd0);
        chk({tag, "_sdv"},   {31'b0, bus.sdv_o},   32'd0);
        chk({tag, "_last"},  {31'b0, bus.last_o},  32'd0);
        chk({tag, "_ready"}, {31'b0, bus.ready_o}, 32'd1);
    endtask

    initial begin
        rstn = 1'b0;
        bus.en_i = 1'b0; bus.valid_i = 1'b0; bus.data_i = '0; bus.dir_i = 1'b0;
        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // 1: 0xB4 MSB first
        clr();
        cycle(1'b1, 1'b1, 8'hB4, 1'b0);
        repeat (FRAME) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("t1_bits", cap, E1);
        chk("t1_len", capn, FRAME);
        chk("t1_lastn", lastn, 1);
        chk("t1_lastpos", lastpos, FRAME);

        // 2: 0xB4 LSB first
        clr();
        cycle(1'b1, 1'b1, 8'hB4, 1'b1);
        repeat (FRAME) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("t2_bits", cap, E2);
        chk("t2_lastpos", lastpos, FRAME);

        // 3: stall for 3 cycles after the 2nd bit is consumed
        clr();
        cycle(1'b1, 1'b1, 8'hFF, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (FRAME - 2) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("t3_span", capn, FRAME + 3);
        chk("t3_lastn", lastn, 1);

        // 4: back-to-back frames, third word offered mid-frame
        clr();
        cycle(1'b1, 1'b1, 8'h0F, 1'b0);
        repeat (FRAME) cycle(1'b1, 1'b1, 8'hF0, 1'b0);
        repeat (4) cycle(1'b1, 1'b1, 8'h55, 1'b0);
        repeat (FRAME - 4) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("t4_bits", cap, E4);
        chk("t4_len", capn, 2 * FRAME);
        chk("t4_sdvlow", sdvlow, 1);
        chk("t4_readyn", readyn, 3);
        chk("t4_lastn", lastn, 2);

        // 5: reset mid-frame, then restart
        clr();
        cycle(1'b1, 1'b1, 8'hAA, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        #2;
        rstn = 1'b0;
        q.delete();
        #1;
        chk_reset_outputs("t5_abort");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        clr();
        repeat (2) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("t5_quiet", capn + lastn, 0);
        cycle(1'b1, 1'b1, 8'h80, 1'b0);
        repeat (FRAME) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("t5_bits", cap, E5);

        // 6: parity tail (or plain 8-bit frame without it)
        clr();
        cycle(1'b1, 1'b1, 8'h07, 1'b0);
        repeat (FRAME) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("t6a_bits", cap, E6A);
        chk("t6a_lastpos", lastpos, FRAME);
        clr();
        cycle(1'b1, 1'b1, 8'h03, 1'b0);
        repeat (FRAME) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("t6b_bits", cap, E6B);
        chk("t6b_lastpos", lastpos, FRAME);

        // Random traffic against the model
        repeat (400) begin
            cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  W'($urandom),
                  1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
